// File: rtl/ifu_fetch.sv
// ifu_fetch: sequential-PC instruction fetch front end with a DEPTH-entry in-order return FIFO.
// Rev 1.0 - initial release.
`default_nettype none

module ifu_fetch #(
  parameter int              XLEN      = 32,
  parameter int              INSTR_LEN = 32,
  parameter int              DEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [XLEN-1:0]      imem_req_addr,
  input  logic                 imem_rsp_valid,
  input  logic [INSTR_LEN-1:0] imem_rsp_data,
  output logic [INSTR_LEN-1:0] instr,
  output logic                 instr_valid,
  output logic [XLEN-1:0]      instr_tag,
  input  logic                 pipe_stall,
  input  logic                 pipe_flush,
  input  logic [XLEN-1:0]      flush_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = PW + 3;
  localparam logic [INSTR_LEN-1:0] NOP = INSTR_LEN'(32'h0000_0013);

  logic [XLEN-1:0]      pc_q, pc_d;
  logic [PW-1:0]        head_q, head_d, tail_q, tail_d, fill_q, fill_d;
  logic [CW-1:0]        nfill_q, nfill_d, out_q, out_d, drop_q, drop_d;
  logic [DEPTH-1:0]     filled_q;
  logic [XLEN-1:0]      tag_q  [DEPTH];
  logic [INSTR_LEN-1:0] data_q [DEPTH];

  logic [SW-1:0] used;
  logic          issue, rsp_drop, rsp_fill, pop;

  // Credit counts returned-but-unconsumed entries, requests in flight and responses still to be discarded.
  assign used           = SW'(nfill_q) + SW'(out_q) + SW'(drop_q);
  assign imem_req_valid = ~rst & ~pipe_flush & (used < SW'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign issue          = imem_req_valid & imem_req_ready;
  assign rsp_drop       = imem_rsp_valid & (drop_q != '0);
  assign rsp_fill       = imem_rsp_valid & (drop_q == '0) & ~pipe_flush;

  assign instr_valid = filled_q[head_q];
  assign instr       = instr_valid ? data_q[head_q] : NOP;
  assign instr_tag   = instr_valid ? tag_q[head_q] : '0;
  assign pop         = instr_valid & ~pipe_stall & ~pipe_flush;

  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    fill_d  = fill_q;
    nfill_d = nfill_q;
    out_d   = out_q;
    drop_d  = drop_q;
    if (pipe_flush) begin
      pc_d    = flush_pc & ~XLEN'(3);
      head_d  = '0;
      tail_d  = '0;
      fill_d  = '0;
      nfill_d = '0;
      out_d   = '0;
      // Everything still in flight must be discarded when it eventually returns.
      drop_d  = drop_q + out_q - CW'(imem_rsp_valid);
    end else begin
      if (issue) begin
        pc_d   = pc_q + XLEN'(4);
        tail_d = tail_q + PW'(1);
      end
      if (rsp_drop) drop_d = drop_q - CW'(1);
      if (rsp_fill) fill_d = fill_q + PW'(1);
      if (pop)      head_d = head_q + PW'(1);
      nfill_d = nfill_q + CW'(rsp_fill) - CW'(pop);
      out_d   = out_q + CW'(issue) - CW'(rsp_fill);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      head_q   <= '0;
      tail_q   <= '0;
      fill_q   <= '0;
      nfill_q  <= '0;
      out_q    <= '0;
      drop_q   <= '0;
      filled_q <= '0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      fill_q  <= fill_d;
      nfill_q <= nfill_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
      if (pipe_flush) begin
        filled_q <= '0;
      end else begin
        if (pop)      filled_q[head_q] <= 1'b0;
        if (rsp_fill) filled_q[fill_q] <= 1'b1;
      end
    end
  end

  // Payload storage needs no reset: the filled bits qualify every read.
  always_ff @(posedge clk) begin
    if (issue)    tag_q[tail_q]  <= pc_q;
    if (rsp_fill) data_q[fill_q] <= imem_rsp_data;
  end

  a_credit_bound : assert property (@(posedge clk) disable iff (rst) used <= SW'(DEPTH));
  a_no_stray_rsp : assert property (@(posedge clk) disable iff (rst)
                                    imem_rsp_valid |-> ((out_q != '0) || (drop_q != '0)));

endmodule

`default_nettype wire
